// File: rtl/filter_test_sequencer_pkg.sv
// Shared types and constants for the filter characterisation sequencer.
// Imported by the sequencer top and its peak tracker.
package filter_test_sequencer_pkg;

  localparam int SIZE_DELAY       = 8;
  localparam int SIZE_FILTER_DATA = 16;
  localparam int NUM_FILTERS_TEST = 21;

  typedef logic signed [SIZE_FILTER_DATA-1:0] filter_data_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_TRIG    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_REPORT  = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } seq_state_t;

  // Most-negative sample value, so the first captured sample always wins.
  localparam filter_data_t PEAK_INIT = {1'b1, {(SIZE_FILTER_DATA-1){1'b0}}};

endpackage

// File: rtl/filter_test_sequencer_peak_tracker.sv
// Per-channel signed running maximum of the filter outputs.
// clear has priority over enable.
module filter_test_sequencer_peak_tracker
  import filter_test_sequencer_pkg::*;
#(
  parameter int NUM_FILTERS = NUM_FILTERS_TEST
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    clear,
  input  logic                                    enable,
  input  logic [NUM_FILTERS*SIZE_FILTER_DATA-1:0] filter_data,
  output filter_data_t                            peaks [NUM_FILTERS]
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FILTERS; i++) peaks[i] <= PEAK_INIT;
    end else if (clear) begin
      for (int i = 0; i < NUM_FILTERS; i++) peaks[i] <= PEAK_INIT;
    end else if (enable) begin
      for (int i = 0; i < NUM_FILTERS; i++) begin
        if ($signed(filter_data[i*SIZE_FILTER_DATA +: SIZE_FILTER_DATA]) > peaks[i])
          peaks[i] <= filter_data[i*SIZE_FILTER_DATA +: SIZE_FILTER_DATA];
      end
    end
  end

endmodule

// File: rtl/filter_test_sequencer.sv
// Sweeps the ExpSigGen test delay, captures per-channel signed peaks after
// each trigger and streams one record per enabled channel per delay step.
module filter_test_sequencer
  import filter_test_sequencer_pkg::*;
#(
  parameter int NUM_FILTERS = NUM_FILTERS_TEST,
  parameter int WINDOW_LEN  = 64,
  parameter int SIZE_CNT    = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    cfg_overlay,
  input  logic [SIZE_DELAY-1:0]                   delay_min,
  input  logic [SIZE_DELAY-1:0]                   delay_max,
  input  logic [SIZE_DELAY-1:0]                   delay_step,
  input  logic [SIZE_CNT-1:0]                     pulses_per_step,
  input  logic [NUM_FILTERS-1:0]                  chan_enable,
  input  logic [NUM_FILTERS*SIZE_FILTER_DATA-1:0] filter_data,
  output logic                                    test_overlay,
  output logic                                    test_rate,
  output logic [SIZE_DELAY-1:0]                   test_delay,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    result_valid,
  input  logic                                    result_ready,
  output logic [4:0]                              result_chan,
  output logic [SIZE_DELAY-1:0]                   result_delay,
  output filter_data_t                            result_peak,
  output seq_state_t                              state_dbg
);

  // Result port: a record moves on every cycle with result_valid & result_ready;
  // while result_valid is high and result_ready low, all result fields hold.

  seq_state_t             state;
  logic [SIZE_DELAY-1:0]  cfg_delay_max;
  logic [SIZE_DELAY-1:0]  cfg_step;
  logic [SIZE_CNT-1:0]    cfg_pulses;
  logic [NUM_FILTERS-1:0] cfg_enable;
  logic [SIZE_CNT-1:0]    pulse_cnt;
  logic [SIZE_CNT-1:0]    win_cnt;
  logic [NUM_FILTERS-1:0] pend;

  logic [NUM_FILTERS-1:0] pend_after;
  logic [4:0]             next_chan;
  logic                   capture_last;
  logic [SIZE_CNT-1:0]    pulse_next;
  logic [SIZE_DELAY:0]    delay_sum;
  filter_data_t           peaks [NUM_FILTERS];

  assign state_dbg = state;

  filter_test_sequencer_peak_tracker #(
    .NUM_FILTERS (NUM_FILTERS)
  ) u_peak (
    .clk         (clk),
    .reset       (reset),
    .clear       (state == ST_ARM),
    .enable      (state == ST_CAPTURE),
    .filter_data (filter_data),
    .peaks       (peaks)
  );

  // Channels still owed a record once any transfer this cycle is retired.
  always_comb begin
    pend_after = pend;
    if (result_valid && result_ready) pend_after[result_chan] = 1'b0;
    next_chan = '0;
    for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
      if (pend_after[i]) next_chan = 5'(i);
    end
  end

  assign capture_last = (win_cnt == SIZE_CNT'(WINDOW_LEN - 1));
  assign pulse_next   = pulse_cnt + SIZE_CNT'(1);
  // One extra bit so a step past an all-ones delay_max cannot wrap.
  assign delay_sum    = {1'b0, test_delay} + {1'b0, cfg_step};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      test_overlay  <= 1'b0;
      test_rate     <= 1'b0;
      test_delay    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result_valid  <= 1'b0;
      result_chan   <= '0;
      result_delay  <= '0;
      result_peak   <= '0;
      cfg_delay_max <= '0;
      cfg_step      <= '0;
      cfg_pulses    <= '0;
      cfg_enable    <= '0;
      pulse_cnt     <= '0;
      win_cnt       <= '0;
      pend          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            test_delay    <= delay_min;
            test_overlay  <= cfg_overlay;
            busy          <= 1'b1;
            cfg_delay_max <= delay_max;
            cfg_step      <= (delay_step == '0) ? SIZE_DELAY'(1) : delay_step;
            cfg_pulses    <= (pulses_per_step == '0) ? SIZE_CNT'(1) : pulses_per_step;
            cfg_enable    <= chan_enable;
            state         <= ST_ARM;
          end
        end
        ST_ARM: begin
          pulse_cnt <= '0;
          test_rate <= 1'b1;
          state     <= ST_TRIG;
        end
        ST_TRIG: begin
          test_rate <= 1'b0;
          win_cnt   <= '0;
          state     <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (capture_last) begin
            pulse_cnt <= pulse_next;
            if (pulse_next < cfg_pulses) begin
              test_rate <= 1'b1;
              state     <= ST_TRIG;
            end else begin
              pend  <= cfg_enable;
              state <= ST_REPORT;
            end
          end else begin
            win_cnt <= win_cnt + SIZE_CNT'(1);
          end
        end
        ST_REPORT: begin
          if (!(result_valid && !result_ready)) begin
            pend <= pend_after;
            if (|pend_after) begin
              result_valid <= 1'b1;
              result_chan  <= next_chan;
              result_delay <= test_delay;
              result_peak  <= peaks[next_chan];
            end else begin
              result_valid <= 1'b0;
              state        <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          if (delay_sum > {1'b0, cfg_delay_max}) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            test_delay <= delay_sum[SIZE_DELAY-1:0];
            state      <= ST_ARM;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_test_sequencer.sv
// Directed bench for filter_test_sequencer: sweeps, backpressure, signed peaks,
// corner configurations and mid-sweep reset, checked against an expected queue.
module tb_filter_test_sequencer;
  import filter_test_sequencer_pkg::*;

  localparam int NF  = 21;
  localparam int W   = SIZE_FILTER_DATA;
  localparam int DW  = SIZE_DELAY;
  localparam int WIN = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                start = 1'b0;
  logic                cfg_overlay = 1'b0;
  logic [DW-1:0]       delay_min = '0;
  logic [DW-1:0]       delay_max = '0;
  logic [DW-1:0]       delay_step = '0;
  logic [15:0]         pulses_per_step = '0;
  logic [NF-1:0]       chan_enable = '0;
  logic [NF*W-1:0]     filter_data;
  logic                result_ready = 1'b1;
  logic                test_overlay, test_rate, busy, done, result_valid;
  logic [DW-1:0]       test_delay, result_delay;
  logic [4:0]          result_chan;
  filter_data_t        result_peak;
  seq_state_t          state_dbg;

  logic signed [W-1:0] ch_val [NF];

  always_comb begin
    filter_data = '0;
    for (int i = 0; i < NF; i++) filter_data[i*W +: W] = ch_val[i];
  end

  filter_test_sequencer #(
    .NUM_FILTERS (NF),
    .WINDOW_LEN  (WIN),
    .SIZE_CNT    (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .cfg_overlay     (cfg_overlay),
    .delay_min       (delay_min),
    .delay_max       (delay_max),
    .delay_step      (delay_step),
    .pulses_per_step (pulses_per_step),
    .chan_enable     (chan_enable),
    .filter_data     (filter_data),
    .test_overlay    (test_overlay),
    .test_rate       (test_rate),
    .test_delay      (test_delay),
    .busy            (busy),
    .done            (done),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_chan     (result_chan),
    .result_delay    (result_delay),
    .result_peak     (result_peak),
    .state_dbg       (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int trig_cnt = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];
  logic        hold_pend = 1'b0;
  logic [31:0] held = '0;
  wire  [31:0] rec = {3'b0, result_chan, result_delay, result_peak};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] mk_rec(input int chan, input int delay, input logic [W-1:0] peak);
    return {3'b0, 5'(chan), 8'(delay), peak};
  endfunction

  always @(negedge clk) begin
    if (test_rate) trig_cnt++;
    if (done) done_cnt++;
    if (hold_pend) check("hold", {result_valid, rec[30:0]}, {1'b1, held[30:0]});
    hold_pend = result_valid && !result_ready;
    held = rec;
    if (result_valid && result_ready) begin
      if (exp_q.size() == 0) check("rec_unexpected", 32'(exp_q.size()), 32'd1);
      else check("rec", rec, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_chans(input int base, input int stride);
    for (int i = 0; i < NF; i++) ch_val[i] = W'(base + stride * i);
  endtask

  task automatic pulse_start(input logic ov, input int dmin, input int dmax, input int step,
                             input int pulses, input logic [NF-1:0] en);
    cfg_overlay     = ov;
    delay_min       = DW'(dmin);
    delay_max       = DW'(dmax);
    delay_step      = DW'(step);
    pulses_per_step = 16'(pulses);
    chan_enable     = en;
    start           = 1'b1;
    tick();
    start           = 1'b0;
    // Garbage after acceptance must not affect the running sweep.
    cfg_overlay     = ~ov;
    delay_min       = 8'hA5;
    delay_max       = 8'h00;
    delay_step      = 8'h33;
    pulses_per_step = 16'd7;
    chan_enable     = '1;
  endtask

  task automatic expect_sweep(input int dmin, input int dmax, input int step,
                              input logic [NF-1:0] en, output int steps);
    int d;
    int s;
    d = dmin;
    s = (step == 0) ? 1 : step;
    steps = 0;
    do begin
      for (int c = 0; c < NF; c++) if (en[c]) exp_q.push_back(mk_rec(c, d, ch_val[c]));
      steps++;
      d += s;
    end while (d <= dmax);
  endtask

  task automatic wait_done(input int budget);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done_cnt, base + 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_width", done, 0);
    check("rec_left", exp_q.size(), 0);
  endtask

  task automatic wait_trig(input int budget);
    int n;
    n = 0;
    while (!test_rate && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("trig_seen", test_rate, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_done"},    done, 0);
    check({tag, "_valid"},   result_valid, 0);
    check({tag, "_rate"},    test_rate, 0);
    check({tag, "_delay"},   test_delay, 0);
    check({tag, "_overlay"}, test_overlay, 0);
    check({tag, "_state"},   32'(state_dbg), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int steps;
    int t0;
    int d0;
    logic signed [W-1:0] v0 [8];
    logic signed [W-1:0] v1 [8];

    set_chans(0, 0);
    repeat (3) @(negedge clk);
    check_idle("reset");
    tick();
    reset = 1'b1;
    tick();

    // Single step, channel 0 constant 37.
    set_chans(37, 5);
    expect_sweep(10, 10, 1, 21'h1, steps);
    t0 = trig_cnt;
    pulse_start(1'b1, 10, 10, 1, 1, 21'h1);
    wait_done(500);
    check("single_trig", trig_cnt - t0, 1);
    check("single_delay_hold", test_delay, 10);
    check("single_overlay_hold", test_overlay, 1);

    // Sweep 0..20 step 5, two pulses, channels 0 and 2.
    tick();
    set_chans(-40, 9);
    expect_sweep(0, 20, 5, 21'h5, steps);
    check("sweep_steps_model", steps, 5);
    t0 = trig_cnt;
    pulse_start(1'b0, 0, 20, 5, 2, 21'h5);
    wait_done(3000);
    check("sweep_trig", trig_cnt - t0, 10);
    check("sweep_delay_hold", test_delay, 20);

    // Backpressure: ready low for 7 cycles once the first record shows.
    tick();
    set_chans(100, -3);
    expect_sweep(30, 30, 1, 21'h100003, steps);
    result_ready = 1'b0;
    fork
      begin
        pulse_start(1'b0, 30, 30, 1, 1, 21'h100003);
        wait_done(1000);
      end
      begin
        int n;
        n = 0;
        while (!result_valid && n < 500) begin
          @(negedge clk);
          n++;
        end
        repeat (7) tick();
        check("bp_valid_held", result_valid, 1);
        result_ready = 1'b1;
      end
    join

    // Signed peaks within one window; values outside the window must not count.
    tick();
    set_chans(0, 0);
    ch_val[0] = 16'sd100;
    ch_val[1] = 16'sd0;
    ch_val[2] = 16'sh8000;
    v0 = '{-16'sd5, -16'sd2, -16'sd9, -16'sd9, -16'sd9, -16'sd9, -16'sd9, -16'sd9};
    v1 = '{-16'sd20, -16'sd20, -16'sd20, -16'sd20, -16'sd20, -16'sd20, -16'sd20, -16'sd7};
    exp_q.push_back(mk_rec(0, 40, 16'hFFFE));
    exp_q.push_back(mk_rec(1, 40, 16'hFFF9));
    exp_q.push_back(mk_rec(2, 40, 16'h8000));
    pulse_start(1'b0, 40, 40, 1, 1, 21'h7);
    wait_trig(100);
    for (int k = 0; k < 8; k++) begin
      tick();
      ch_val[0] = v0[k];
      ch_val[1] = v1[k];
    end
    tick();
    ch_val[0] = 16'sd50;
    ch_val[1] = 16'sd50;
    wait_done(500);

    // step = 0 over 3..5.
    tick();
    set_chans(11, 1);
    expect_sweep(3, 5, 0, 21'h1, steps);
    t0 = trig_cnt;
    pulse_start(1'b0, 3, 5, 0, 1, 21'h1);
    wait_done(1000);
    check("step0_trig", trig_cnt - t0, 3);
    check("step0_delay_hold", test_delay, 5);

    // delay_min > delay_max: one step at 8.
    tick();
    expect_sweep(8, 2, 1, 21'h1, steps);
    t0 = trig_cnt;
    pulse_start(1'b1, 8, 2, 1, 1, 21'h1);
    wait_done(500);
    check("minmax_trig", trig_cnt - t0, 1);
    check("minmax_delay_hold", test_delay, 8);

    // No channels enabled: no records, done still pulses.
    tick();
    t0 = trig_cnt;
    pulse_start(1'b0, 1, 1, 1, 1, '0);
    wait_done(500);
    check("noen_trig", trig_cnt - t0, 1);

    // delay_max all ones: must stop after 255, no wrap.
    tick();
    expect_sweep(254, 255, 1, 21'h1, steps);
    t0 = trig_cnt;
    pulse_start(1'b0, 254, 255, 1, 1, 21'h1);
    wait_done(1000);
    check("maxdelay_trig", trig_cnt - t0, 2);
    check("maxdelay_delay_hold", test_delay, 255);

    // Reset mid-capture with a start issued while busy.
    tick();
    set_chans(5, 1);
    d0 = done_cnt;
    pulse_start(1'b1, 9, 9, 1, 1, 21'h1);
    wait_trig(100);
    tick();
    pulse_start(1'b0, 50, 60, 1, 1, '1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_idle("midreset");
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("midreset_no_done", done_cnt, d0);

    // Fresh sweep after reset; a start while busy is ignored.
    expect_sweep(12, 13, 1, 21'h2, steps);
    t0 = trig_cnt;
    pulse_start(1'b0, 12, 13, 1, 1, 21'h2);
    wait_trig(100);
    tick();
    pulse_start(1'b1, 50, 50, 1, 1, '1);
    wait_done(1000);
    check("fresh_trig", trig_cnt - t0, 2);
    check("fresh_delay_hold", test_delay, 13);
    check("fresh_overlay_hold", test_overlay, 0);
    d0 = done_cnt;
    repeat (20) tick();
    check("no_queued_busy", busy, 0);
    check("no_queued_trig", trig_cnt - t0, 2);
    check("no_queued_done", done_cnt, d0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
